// File: rtl/lock_pkg.sv
// Shared types and helpers for the multi-digit lock: state encoding,
// attempt thermometer and digit slicing of a packed code word.
package lock_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3,
        S_PROGRAM  = 3'd4
    } lock_state_t;

    localparam int unsigned MAX_CODE_W  = 256;
    localparam int unsigned MAX_THERM_W = 32;

    // Bit i is set when more than i failures have been counted.
    function automatic logic [MAX_THERM_W-1:0] therm(input int unsigned count,
                                                     input int unsigned max_attempts);
        logic [MAX_THERM_W-1:0] w_bits;
        w_bits = '0;
        for (int unsigned i = 0; i < MAX_THERM_W; i++) begin
            w_bits[i] = (i < count) && (i < max_attempts);
        end
        return w_bits;
    endfunction

    // Digit 0 is the most significant digit of the code word.
    function automatic logic [31:0] get_digit(input logic [MAX_CODE_W-1:0] code,
                                              input int unsigned idx,
                                              input int unsigned digit_w,
                                              input int unsigned code_len);
        logic [31:0] w_mask;
        w_mask = (digit_w >= 32) ? '1 : ((32'd1 << digit_w) - 32'd1);
        return 32'(code >> ((code_len - 1 - idx) * digit_w)) & w_mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock window, lockout period and
// entry timeout; only one of them can be running in any given state.
module lock_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_tick,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    // Flags the tick on which the count reaches zero, so the owner can act on that same edge.
    assign o_zero = i_tick && !i_load && (r_count == W'(1));

endmodule

// File: rtl/digital_lock_seq.sv
// Multi-digit pushbutton lock with attempt counting, lockout, timed relock
// and field reprogramming of the stored code.
module digital_lock_seq
    import lock_pkg::*;
#(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned CODE_LEN       = 4,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned UNLOCK_CYCLES  = 16,
    parameter int unsigned LOCKOUT_CYCLES = 64,
    parameter int unsigned ENTRY_TIMEOUT  = 32,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h10A5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             admin_reset,
    input  logic                             enter,
    input  logic                             prog_en,
    input  logic [DIGIT_W-1:0]               code_in,
    output logic                             unlock_led,
    output logic                             lockout_led,
    output logic [MAX_ATTEMPTS-1:0]          attempt_led,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_cnt,
    output logic                             prog_led,
    output logic                             prog_done
);

    localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned ATT_W   = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned MAX_UL  = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_UL > ENTRY_TIMEOUT) ? MAX_UL : ENTRY_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

    lock_state_t             r_state;
    logic                    r_enter_q;
    logic [CODE_W-1:0]       r_code;
    logic [CODE_W-1:0]       r_shadow;
    logic [CNT_W-1:0]        r_digit_cnt;
    logic [ATT_W-1:0]        r_attempts;
    logic                    r_mismatch;
    logic                    r_unlock_led;
    logic                    r_lockout_led;
    logic [MAX_ATTEMPTS-1:0] r_attempt_led;
    logic                    r_prog_led;
    logic                    r_prog_done;

    lock_state_t             w_state_nxt;
    logic [CODE_W-1:0]       w_code_nxt;
    logic [CODE_W-1:0]       w_shadow_nxt;
    logic [CODE_W-1:0]       w_shadow_upd;
    logic [CNT_W-1:0]        w_digit_cnt_nxt;
    logic [ATT_W-1:0]        w_attempts_nxt;
    logic                    w_mismatch_nxt;
    logic                    w_prog_done_nxt;
    logic                    w_press;
    logic                    w_last_digit;
    logic                    w_digit_bad;
    logic [DIGIT_W-1:0]      w_stored_digit;
    logic                    w_tmr_load;
    logic [TMR_W-1:0]        w_tmr_value;
    logic                    w_tmr_tick;
    logic                    w_tmr_zero;

    lock_timer #(.W(TMR_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .i_tick  (w_tmr_tick),
        .o_zero  (w_tmr_zero)
    );

    assign w_press        = enter & ~r_enter_q;
    assign w_last_digit   = (r_digit_cnt == CNT_W'(CODE_LEN - 1));
    assign w_stored_digit = DIGIT_W'(get_digit(MAX_CODE_W'(r_code), 32'(r_digit_cnt), DIGIT_W, CODE_LEN));
    assign w_digit_bad    = (code_in != w_stored_digit);

    always_comb begin
        w_shadow_upd = r_shadow;
        for (int unsigned d = 0; d < CODE_LEN; d++) begin
            if (d == 32'(r_digit_cnt)) begin
                w_shadow_upd[(CODE_LEN-1-d)*DIGIT_W +: DIGIT_W] = code_in;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_shadow_nxt    = r_shadow;
        w_digit_cnt_nxt = r_digit_cnt;
        w_attempts_nxt  = r_attempts;
        w_mismatch_nxt  = r_mismatch;
        w_prog_done_nxt = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_value     = '0;
        w_tmr_tick      = 1'b0;

        if (admin_reset) begin
            w_state_nxt     = S_IDLE;
            w_shadow_nxt    = '0;
            w_digit_cnt_nxt = '0;
            w_attempts_nxt  = '0;
            w_mismatch_nxt  = 1'b0;
            w_tmr_load      = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_ENTRY: begin
                    if (w_press) begin
                        if (w_last_digit) begin
                            w_digit_cnt_nxt = '0;
                            w_mismatch_nxt  = 1'b0;
                            if (!(r_mismatch || w_digit_bad)) begin
                                w_state_nxt    = S_UNLOCKED;
                                w_attempts_nxt = '0;
                                w_tmr_load     = 1'b1;
                                w_tmr_value    = TMR_W'(UNLOCK_CYCLES);
                            end else if (r_attempts == ATT_W'(MAX_ATTEMPTS - 1)) begin
                                w_state_nxt    = S_LOCKOUT;
                                w_attempts_nxt = ATT_W'(MAX_ATTEMPTS);
                                w_tmr_load     = 1'b1;
                                w_tmr_value    = TMR_W'(LOCKOUT_CYCLES);
                            end else begin
                                w_state_nxt    = S_IDLE;
                                w_attempts_nxt = r_attempts + ATT_W'(1);
                            end
                        end else begin
                            w_state_nxt     = S_ENTRY;
                            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
                            w_mismatch_nxt  = r_mismatch | w_digit_bad;
                            w_tmr_load      = 1'b1;
                            w_tmr_value     = TMR_W'(ENTRY_TIMEOUT);
                        end
                    end else if ((r_state == S_ENTRY) && (ENTRY_TIMEOUT != 0)) begin
                        w_tmr_tick = 1'b1;
                        if (w_tmr_zero) begin
                            w_state_nxt     = S_IDLE;
                            w_digit_cnt_nxt = '0;
                            w_mismatch_nxt  = 1'b0;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (prog_en) begin
                        w_state_nxt     = S_PROGRAM;
                        w_digit_cnt_nxt = '0;
                        w_shadow_nxt    = '0;
                    end else begin
                        w_tmr_tick = 1'b1;
                        if (w_tmr_zero) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_PROGRAM: begin
                    if (w_press) begin
                        if (w_last_digit) begin
                            w_code_nxt      = w_shadow_upd;
                            w_shadow_nxt    = '0;
                            w_digit_cnt_nxt = '0;
                            w_prog_done_nxt = 1'b1;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_shadow_nxt    = w_shadow_upd;
                            w_digit_cnt_nxt = r_digit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOCKOUT: begin
                    if (LOCKOUT_CYCLES != 0) begin
                        w_tmr_tick = 1'b1;
                        if (w_tmr_zero) begin
                            w_state_nxt    = S_IDLE;
                            w_attempts_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // LED registers are driven from the next state so they track r_state without extra lag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_enter_q     <= 1'b0;
            r_code        <= DEFAULT_CODE;
            r_shadow      <= '0;
            r_digit_cnt   <= '0;
            r_attempts    <= '0;
            r_mismatch    <= 1'b0;
            r_unlock_led  <= 1'b0;
            r_lockout_led <= 1'b0;
            r_attempt_led <= '0;
            r_prog_led    <= 1'b0;
            r_prog_done   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_enter_q     <= enter;
            r_code        <= w_code_nxt;
            r_shadow      <= w_shadow_nxt;
            r_digit_cnt   <= w_digit_cnt_nxt;
            r_attempts    <= w_attempts_nxt;
            r_mismatch    <= w_mismatch_nxt;
            r_unlock_led  <= (w_state_nxt == S_UNLOCKED);
            r_lockout_led <= (w_state_nxt == S_LOCKOUT);
            r_attempt_led <= (w_state_nxt == S_LOCKOUT) ? '1
                           : MAX_ATTEMPTS'(therm(32'(w_attempts_nxt), MAX_ATTEMPTS));
            r_prog_led    <= (w_state_nxt == S_PROGRAM);
            r_prog_done   <= w_prog_done_nxt;
        end
    end

    assign unlock_led  = r_unlock_led;
    assign lockout_led = r_lockout_led;
    assign attempt_led = r_attempt_led;
    assign digit_cnt   = r_digit_cnt;
    assign prog_led    = r_prog_led;
    assign prog_done   = r_prog_done;

endmodule

// File: tb/tb_digital_lock_seq.sv
// Bench for digital_lock_seq: directed scenarios followed by randomized code
// entries, checked against a transaction-level model of the lock.
module tb_digital_lock_seq;

    localparam int DIGIT_W        = 4;
    localparam int CODE_LEN       = 4;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int UNLOCK_CYCLES  = 16;
    localparam int LOCKOUT_CYCLES = 64;
    localparam int ENTRY_TIMEOUT  = 32;
    localparam int CNT_W          = $clog2(CODE_LEN + 1);

    typedef int code_t [CODE_LEN];

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    admin_reset;
    logic                    enter;
    logic                    prog_en;
    logic [DIGIT_W-1:0]      code_in;
    logic                    unlock_led;
    logic                    lockout_led;
    logic [MAX_ATTEMPTS-1:0] attempt_led;
    logic [CNT_W-1:0]        digit_cnt;
    logic                    prog_led;
    logic                    prog_done;

    int unsigned tests    = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    // Model: stored code as a digit list plus the consecutive-failure count.
    code_t m_code;
    int    m_attempts;

    digital_lock_seq #(
        .DIGIT_W        (DIGIT_W),
        .CODE_LEN       (CODE_LEN),
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .ENTRY_TIMEOUT  (ENTRY_TIMEOUT),
        .DEFAULT_CODE   (16'h10A5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .admin_reset (admin_reset),
        .enter       (enter),
        .prog_en     (prog_en),
        .code_in     (code_in),
        .unlock_led  (unlock_led),
        .lockout_led (lockout_led),
        .attempt_led (attempt_led),
        .digit_cnt   (digit_cnt),
        .prog_led    (prog_led),
        .prog_done   (prog_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [MAX_ATTEMPTS-1:0] exp_att(input int n);
        return MAX_ATTEMPTS'((1 << n) - 1);
    endfunction

    task automatic press_one(input int d);
        code_in = DIGIT_W'(d);
        enter   = 1'b1;
        @(posedge clk);
        #1;
        enter   = 1'b0;
    endtask

    // Enters a full code; returns 0 = rejected, 1 = unlocked, 2 = locked out.
    task automatic enter_code(input code_t d, input int hold_max, input int gap_max,
                              input bit ignored, output int res, output int unsigned ev);
        bit match;
        res = 0;
        ev  = 0;
        for (int i = 0; i < CODE_LEN; i++) begin
            code_in = DIGIT_W'(d[i]);
            enter   = 1'b1;
            @(posedge clk);
            #1;
            if (i < CODE_LEN - 1) begin
                chk("digit_cnt_step", 32'(digit_cnt), ignored ? 0 : i + 1);
                for (int h = 1; h < $urandom_range(hold_max, 1); h++) begin
                    code_in = DIGIT_W'($urandom);
                    tick(1);
                end
                enter = 1'b0;
                tick($urandom_range(gap_max, 1));
            end else begin
                enter = 1'b0;
                ev    = cyc;
                if (ignored) begin
                    chk("ignored_lockout_led", 32'(lockout_led), 1);
                    chk("ignored_attempt_led", 32'(attempt_led), 32'(exp_att(MAX_ATTEMPTS)));
                    chk("ignored_digit_cnt", 32'(digit_cnt), 0);
                end else begin
                    match = 1'b1;
                    for (int k = 0; k < CODE_LEN; k++) begin
                        if (d[k] != m_code[k]) match = 1'b0;
                    end
                    if (match) begin
                        m_attempts = 0;
                        res = 1;
                    end else begin
                        m_attempts++;
                        res = (m_attempts >= MAX_ATTEMPTS) ? 2 : 0;
                    end
                    chk("entry_unlock_led", 32'(unlock_led), (res == 1) ? 1 : 0);
                    chk("entry_lockout_led", 32'(lockout_led), (res == 2) ? 1 : 0);
                    chk("entry_attempt_led", 32'(attempt_led), 32'(exp_att(m_attempts)));
                    chk("entry_digit_cnt", 32'(digit_cnt), 0);
                end
            end
        end
        tick(1);
    endtask

    task automatic wait_unlock_expiry(input int unsigned ev);
        while (cyc < ev + UNLOCK_CYCLES - 1) tick(1);
        chk("unlock_window_last", 32'(unlock_led), 1);
        tick(1);
        chk("unlock_window_over", 32'(unlock_led), 0);
    endtask

    task automatic wait_lockout_expiry(input int unsigned ev);
        while (cyc < ev + LOCKOUT_CYCLES - 1) tick(1);
        chk("lockout_last", 32'(lockout_led), 1);
        tick(1);
        m_attempts = 0;
        chk("lockout_over", 32'(lockout_led), 0);
        chk("lockout_over_attempts", 32'(attempt_led), 0);
    endtask

    task automatic admin_clear();
        admin_reset = 1'b1;
        @(posedge clk);
        #1;
        admin_reset = 1'b0;
        m_attempts  = 0;
        chk("admin_lockout_led", 32'(lockout_led), 0);
        chk("admin_attempt_led", 32'(attempt_led), 0);
        chk("admin_unlock_led", 32'(unlock_led), 0);
        chk("admin_prog_led", 32'(prog_led), 0);
        chk("admin_digit_cnt", 32'(digit_cnt), 0);
    endtask

    initial begin
        code_t       c_def;
        code_t       c_bad;
        code_t       c_new;
        code_t       c_rnd;
        int          res;
        int unsigned ev;

        c_def = '{1, 0, 10, 5};
        c_bad = '{1, 1, 1, 1};
        c_new = '{7, 3, 3, 9};
        m_code     = c_def;
        m_attempts = 0;

        reset       = 1'b1;
        admin_reset = 1'b0;
        enter       = 1'b0;
        prog_en     = 1'b0;
        code_in     = '0;
        tick(3);
        reset = 1'b0;
        chk("rst_unlock_led", 32'(unlock_led), 0);
        chk("rst_lockout_led", 32'(lockout_led), 0);
        chk("rst_attempt_led", 32'(attempt_led), 0);
        chk("rst_digit_cnt", 32'(digit_cnt), 0);
        chk("rst_prog_led", 32'(prog_led), 0);
        chk("rst_prog_done", 32'(prog_done), 0);
        tick(1);

        // Default code unlocks, then relocks after the window.
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        chk("default_unlocks", 32'(res), 1);
        wait_unlock_expiry(ev);

        // Three failures lock out; the correct code is ignored while locked.
        for (int t = 0; t < MAX_ATTEMPTS; t++) enter_code(c_bad, 1, 1, 1'b0, res, ev);
        chk("third_fail_locks", 32'(res), 2);
        begin
            int unsigned lock_ev;
            int unsigned dummy_ev;
            lock_ev = ev;
            enter_code(c_def, 1, 1, 1'b1, res, dummy_ev);
            chk("locked_unlock_led", 32'(unlock_led), 0);
            wait_lockout_expiry(lock_ev);
        end

        // Admin override during lockout; a press on the same cycle is dropped.
        for (int t = 0; t < MAX_ATTEMPTS; t++) enter_code(c_bad, 1, 1, 1'b0, res, ev);
        code_in     = 4'd1;
        enter       = 1'b1;
        admin_reset = 1'b1;
        @(posedge clk);
        #1;
        admin_reset = 1'b0;
        enter       = 1'b0;
        m_attempts  = 0;
        chk("admin_press_lockout", 32'(lockout_led), 0);
        chk("admin_press_attempt", 32'(attempt_led), 0);
        chk("admin_press_digit_cnt", 32'(digit_cnt), 0);
        tick(1);
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        chk("admin_then_unlock", 32'(res), 1);
        wait_unlock_expiry(ev);

        // Partial entry times out without counting as an attempt.
        enter_code(c_bad, 1, 1, 1'b0, res, ev);
        press_one(1);
        tick(1);
        press_one(0);
        chk("partial_digit_cnt", 32'(digit_cnt), 2);
        tick(ENTRY_TIMEOUT - 1);
        chk("timeout_not_yet", 32'(digit_cnt), 2);
        tick(1);
        chk("timeout_digit_cnt", 32'(digit_cnt), 0);
        chk("timeout_attempt_led", 32'(attempt_led), 32'(exp_att(m_attempts)));
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        chk("after_timeout_unlock", 32'(res), 1);
        wait_unlock_expiry(ev);

        // Programming aborted by admin_reset keeps the old code.
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        prog_en = 1'b1;
        tick(1);
        chk("abort_prog_led", 32'(prog_led), 1);
        prog_en = 1'b0;
        press_one(2);
        tick(1);
        press_one(4);
        chk("abort_digit_cnt", 32'(digit_cnt), 2);
        admin_clear();
        tick(1);
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        chk("abort_old_code", 32'(res), 1);
        wait_unlock_expiry(ev);

        // Holding enter for 10 clocks yields a single digit.
        code_in = 4'd1;
        enter   = 1'b1;
        for (int h = 0; h < 10; h++) begin
            tick(1);
            code_in = DIGIT_W'($urandom);
        end
        chk("held_enter_digit_cnt", 32'(digit_cnt), 1);
        enter = 1'b0;
        tick(1);
        press_one(0);
        tick(1);
        press_one(10);
        tick(1);
        press_one(5);
        ev = cyc;
        chk("held_enter_unlock", 32'(unlock_led), 1);
        chk("held_enter_attempts", 32'(attempt_led), 0);
        tick(1);
        wait_unlock_expiry(ev);

        // Reprogram to 7339; old code fails, new code unlocks and clears attempts.
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        prog_en = 1'b1;
        tick(1);
        chk("prog_led_on", 32'(prog_led), 1);
        prog_en = 1'b0;
        for (int i = 0; i < CODE_LEN; i++) begin
            press_one(c_new[i]);
            if (i < CODE_LEN - 1) begin
                chk("prog_no_done_yet", 32'(prog_done), 0);
                tick(1);
            end
        end
        chk("prog_done_pulse", 32'(prog_done), 1);
        chk("prog_led_off", 32'(prog_led), 0);
        chk("prog_digit_cnt", 32'(digit_cnt), 0);
        tick(1);
        chk("prog_done_cleared", 32'(prog_done), 0);
        m_code = c_new;
        enter_code(c_def, 1, 1, 1'b0, res, ev);
        chk("old_code_rejected", 32'(attempt_led), 32'(exp_att(1)));
        enter_code(c_new, 1, 1, 1'b0, res, ev);
        chk("new_code_unlocks", 32'(res), 1);
        wait_unlock_expiry(ev);

        // Randomized entries: correct, random, or correct with one digit corrupted.
        for (int t = 0; t < 24; t++) begin
            int kind;
            kind = $urandom_range(2, 0);
            for (int i = 0; i < CODE_LEN; i++) begin
                c_rnd[i] = (kind == 1) ? int'($urandom_range(15, 0)) : m_code[i];
            end
            if (kind == 2) begin
                int pos;
                pos = $urandom_range(CODE_LEN - 1, 0);
                c_rnd[pos] = c_rnd[pos] ^ int'($urandom_range(15, 1));
            end
            enter_code(c_rnd, 3, 3, 1'b0, res, ev);
            if (res == 1) begin
                wait_unlock_expiry(ev);
            end else if (res == 2) begin
                if ($urandom_range(1, 0) == 1) admin_clear();
                else wait_lockout_expiry(ev);
                tick(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
